// File: rtl/band_gain_mixer_if.sv
// Sample/gain bus between the filter bank side and the band gain mixer.
// The master drives the strobe, band samples, gain codes and mute; the mixer
// (slave) returns the mixed sample together with its status flags.
interface band_gain_mixer_if #(
  parameter int SIZE = 22,
  parameter int GW   = 4
);
  logic            EN;
  logic [SIZE-1:0] y1;
  logic [SIZE-1:0] y2;
  logic [SIZE-1:0] y3;
  logic [GW-1:0]   g1;
  logic [GW-1:0]   g2;
  logic [GW-1:0]   g3;
  logic            mute;
  logic [SIZE-1:0] y;
  logic            valid;
  logic            sat;
  logic            busy;
  logic            ovr;

  modport master (
    output EN, y1, y2, y3, g1, g2, g3, mute,
    input  y, valid, sat, busy, ovr
  );

  modport slave (
    input  EN, y1, y2, y3, g1, g2, g3, mute,
    output y, valid, sat, busy, ovr
  );
endinterface

// File: rtl/band_gain_mixer.sv
// Equalizer output stage: weights the three filter-bank bands by unsigned
// gain codes (code/8), sums them and saturates to the sample format.
// One multiplier is shared across the bands, sequenced by a 5-state FSM,
// so a new sample can be accepted every 5 clocks.
module band_gain_mixer #(
  parameter int SIGN = 1,
  parameter int PF   = 14,
  parameter int MAG  = 7,
  parameter int GW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  band_gain_mixer_if.slave bus
);
  localparam int SIZE   = SIGN + PF + MAG;
  localparam int ACC_W  = SIZE + GW + 3;
  localparam int PROD_W = SIZE + GW + 1;

  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((2 ** (SIZE - 1)) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;
  localparam logic [SIZE-1:0] Y_MAX = {1'b0, {(SIZE - 1){1'b1}}};
  localparam logic [SIZE-1:0] Y_MIN = {1'b1, {(SIZE - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, OUT} state_t;

  // Inputs captured on the accepting strobe; the bus may change afterwards.
  typedef struct packed {
    logic [2:0][SIZE-1:0] ys;
    logic [2:0][GW-1:0]   gs;
    logic                 mute;
  } snap_t;

  state_t                   state, state_nxt;
  snap_t                    snap;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SIZE-1:0]   ys_sel;
  logic signed [GW:0]       gs_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  r;
  logic [SIZE-1:0]          y_res;
  logic                     sat_res;
  logic [SIZE-1:0]          y_q;
  logic                     valid_q;
  logic                     sat_q;
  logic                     ovr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fixed walk through the three MAC steps once a strobe is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.EN) state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = MAC3;
      MAC3:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Steer the shared multiplier to the band belonging to the current MAC step.
  always_comb begin
    ys_sel = '0;
    gs_ext = '0;
    case (state)
      MAC1: begin ys_sel = snap.ys[0]; gs_ext = {1'b0, snap.gs[0]}; end
      MAC2: begin ys_sel = snap.ys[1]; gs_ext = {1'b0, snap.gs[1]}; end
      MAC3: begin ys_sel = snap.ys[2]; gs_ext = {1'b0, snap.gs[2]}; end
      default: ;
    endcase
    // Product of a SIZE-bit sample and a 0..15 gain always fits in PROD_W.
    prod    = PROD_W'(ys_sel) * PROD_W'(gs_ext);
    acc_nxt = acc + ACC_W'(prod);
  end

  // Scale by 1/8 (floor) and clip into the sample range; mute overrides.
  always_comb begin
    r       = acc >>> 3;
    y_res   = r[SIZE-1:0];
    sat_res = 1'b0;
    if (r > R_MAX) begin
      y_res   = Y_MAX;
      sat_res = 1'b1;
    end else if (r < R_MIN) begin
      y_res   = Y_MIN;
      sat_res = 1'b1;
    end
    if (snap.mute) begin
      y_res   = '0;
      sat_res = 1'b0;
    end
  end

  // Snapshot, accumulate, publish the result and track overrun strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap    <= '0;
      acc     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      if (bus.EN && state != IDLE) ovr_q <= 1'b1;
      case (state)
        IDLE: if (bus.EN) begin
          snap.ys   <= {bus.y3, bus.y2, bus.y1};
          snap.gs   <= {bus.g3, bus.g2, bus.g1};
          snap.mute <= bus.mute;
          acc       <= '0;
        end
        MAC1, MAC2, MAC3: acc <= acc_nxt;
        OUT: begin
          y_q     <= y_res;
          sat_q   <= sat_res;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.sat   = sat_q;
  assign bus.ovr   = ovr_q;
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_band_gain_mixer.sv
// Bench for band_gain_mixer: a driver pushes expected results into a
// scoreboard when the reference model says a strobe is accepted; a monitor
// pops and compares whenever the mixer raises valid.
module tb_band_gain_mixer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  band_gain_mixer_if bus_if ();

  band_gain_mixer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [21:0] y;
    logic        sat;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   last_acc = -1000;
  logic ovr_m    = 1'b0;

  logic signed [21:0] v1, v2, v3;
  logic [3:0]         k1, k2, k3;
  logic               mv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: weighted sum in plain integer arithmetic, /8 with floor,
  // clamp to the signed 22-bit range, mute forces zero.
  function automatic void ref_mix(output logic [21:0] ey, output logic es);
    longint s, r;
    s = longint'(v1) * longint'(k1) + longint'(v2) * longint'(k2)
      + longint'(v3) * longint'(k3);
    r = s >>> 3;
    es = 1'b0;
    if (r > 64'sd2097151) begin
      r = 2097151; es = 1'b1;
    end else if (r < -64'sd2097152) begin
      r = -2097152; es = 1'b1;
    end
    if (mv) begin
      r = 0; es = 1'b0;
    end
    ey = 22'(r);
  endfunction

  // One cycle of stimulus; the model decides acceptance from strobe spacing.
  task automatic drive(input logic r_in, input logic en);
    exp_t e;
    @(negedge clk);
    #1;
    rst        = r_in;
    bus_if.EN  = en;
    bus_if.y1  = v1;
    bus_if.y2  = v2;
    bus_if.y3  = v3;
    bus_if.g1  = k1;
    bus_if.g2  = k2;
    bus_if.g3  = k3;
    bus_if.mute = mv;
    if (r_in) begin
      q.delete();
      last_acc = -1000;
      ovr_m    = 1'b0;
    end else if (en) begin
      if (cyc >= last_acc + 5) begin
        ref_mix(e.y, e.sat);
        e.due = cyc + 5;
        q.push_back(e);
        last_acc = cyc;
      end else begin
        ovr_m = 1'b1;
      end
    end
  endtask

  task automatic set_in(input logic [21:0] a, b, c, input logic [3:0] ga, gb, gc,
                        input logic m);
    v1 = a; v2 = b; v3 = c; k1 = ga; k2 = gb; k3 = gc; mv = m;
  endtask

  task automatic pulse();
    drive(1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0);
  endtask

  // Monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus_if.valid) begin
      n_valid++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got y=0x%0h with no result outstanding (cycle %0d)",
                 bus_if.y, cyc);
      end else begin
        e = q.pop_front();
        chk("y", bus_if.y, e.y);
        chk("sat", bus_if.sat, e.sat);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    int vsnap;
    logic [21:0] pick [6];
    pick[0] = 22'h1FFFFF; pick[1] = 22'h200000; pick[2] = 22'h3FFFFF;
    pick[3] = 22'h000001; pick[4] = 22'h004000; pick[5] = 22'h000000;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    bus_if.EN = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("rst_y", bus_if.y, 0);
    chk("rst_valid", bus_if.valid, 0);
    chk("rst_sat", bus_if.sat, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_ovr", bus_if.ovr, 0);

    // Unity gain on one band, with busy window check.
    set_in(22'h004000, 0, 0, 4'd8, 0, 0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("busy_high", bus_if.busy, 1);
    repeat (3) drive(1'b0, 1'b0);
    chk("busy_out", bus_if.busy, 1);
    drive(1'b0, 1'b0);
    chk("busy_low", bus_if.busy, 0);
    drive(1'b0, 1'b0);

    set_in(22'h004000, 22'h002000, 22'h3FC000, 4'd8, 4'd4, 4'd8, 1'b0); pulse();
    set_in(22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 4'd15, 4'd15, 4'd15, 1'b0); pulse();
    set_in(22'h200000, 22'h200000, 22'h200000, 4'd15, 4'd15, 4'd15, 1'b0); pulse();
    set_in(22'h3FFFFF, 0, 0, 4'd1, 0, 0, 1'b0); pulse();
    set_in(22'h000001, 0, 0, 4'd1, 0, 0, 1'b0); pulse();

    // Second strobe while busy: ignored, sticky overrun.
    set_in(22'h012345, 22'h3ABCDE, 22'h000777, 4'd3, 4'd9, 4'd15, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    set_in(22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 4'd15, 4'd15, 4'd15, 1'b0);
    drive(1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0);
    chk("ovr_set", bus_if.ovr, ovr_m);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("ovr_cleared", bus_if.ovr, 0);
    chk("y_cleared", bus_if.y, 0);

    // Reset in MAC2 together with a strobe: abort, no valid, no overrun.
    vsnap = n_valid;
    set_in(22'h0ABCDE, 0, 0, 4'd8, 0, 0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    repeat (8) drive(1'b0, 1'b0);
    chk("abort_no_valid", n_valid, vsnap);
    chk("abort_y", bus_if.y, 0);
    chk("abort_ovr", bus_if.ovr, 0);

    set_in(22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 4'd15, 4'd15, 4'd15, 1'b1); pulse();

    // Random strobes with random spacing, mixing in edge-case sample values.
    for (int i = 0; i < 200; i++) begin
      v1 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 22'($urandom);
      v2 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 22'($urandom);
      v3 = 22'($urandom);
      k1 = 4'($urandom); k2 = 4'($urandom); k3 = 4'($urandom);
      mv = ($urandom_range(0, 15) == 0);
      drive(1'b0, ($urandom_range(0, 2) == 0));
    end
    // Strobe held high: one sample every 5 clocks.
    for (int i = 0; i < 25; i++) begin
      v1 = 22'($urandom); v2 = 22'($urandom); v3 = 22'($urandom);
      k1 = 4'($urandom); k2 = 4'($urandom); k3 = 4'($urandom);
      mv = 1'b0;
      drive(1'b0, 1'b1);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) drive(1'b0, 1'b0);
    chk("drain", q.size(), 0);
    chk("ovr_final", bus_if.ovr, ovr_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
